// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;
  localparam int          DEPTH_DEF = 256;
  localparam logic [31:0] NOP       = 32'h0000_0000;

  typedef enum logic [1:0] {
    LOAD,
    HOLD,
    RUN,
    ERR
  } state_e;
endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 instruction storage: one synchronous write port, one asynchronous read port.
module imem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset; stale words are masked by the
  // loader's load_count, so clearing DEPTH words would buy nothing.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/imem_loader.sv
// Loads a program image over a valid/ready stream, holds the core in reset, then serves IR.
// Optional build macro IMEM_CHECKSUM_EN: the ld_last word becomes a checksum trailer.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic [31:0]   IR_addr,
  output logic [31:0]   IR,
  output logic          core_rst_n,
  output logic          running,
  output logic          load_err,
  output logic [AW:0]   load_count
);
  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          crn_q, crn_d;
  logic          we;
  logic          hs;
  logic [31:0]   rdata;
  logic [AW-1:0] ridx;
  logic          addr_hi_nz;
  logic          unused_addr_bits;
`ifdef IMEM_CHECKSUM_EN
  logic [31:0]   sum_q, sum_d;
`endif

  assign ld_ready = (state_q == LOAD) & ~rst;
  assign hs       = ld_valid & ld_ready;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we      = 1'b0;
`ifdef IMEM_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      LOAD: begin
        if (hs) begin
`ifdef IMEM_CHECKSUM_EN
          if (ld_last) begin
            // Trailer is valid when it cancels the running sum.
            if (sum_q + ld_data == 32'd0) begin
              state_d = HOLD;
            end else begin
              err_d   = 1'b1;
              state_d = ERR;
            end
          end else begin
            we     = 1'b1;
            wptr_d = wptr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
            sum_d  = sum_q + ld_data;
            if (wptr_q == AW'(DEPTH - 1)) begin
              err_d   = 1'b1;
              state_d = ERR;
            end
          end
`else
          we     = 1'b1;
          wptr_d = wptr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (ld_last) begin
            state_d = HOLD;
          end else if (wptr_q == AW'(DEPTH - 1)) begin
            err_d   = 1'b1;
            state_d = ERR;
          end
`endif
        end
      end
      HOLD:    state_d = RUN;
      default: state_d = state_q;
    endcase
    crn_d = (state_d == RUN);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      wptr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      crn_q   <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      crn_q   <= crn_d;
`ifdef IMEM_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  imem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (wptr_q),
    .wdata (ld_data),
    .raddr (ridx),
    .rdata (rdata)
  );

  // Byte offset within a word carries no information for word fetches.
  assign unused_addr_bits = ^IR_addr[1:0];
  assign ridx             = IR_addr[AW+1:2];
  assign addr_hi_nz       = |IR_addr[31:AW+2];

  assign IR = (state_q == RUN && !addr_hi_nz && ({1'b0, ridx} < cnt_q)) ? rdata : NOP;

  assign running    = (state_q == RUN);
  assign core_rst_n = crn_q;
  assign load_err   = err_q;
  assign load_count = cnt_q;
endmodule
